// File: rtl/inst_fetch_cache.sv
// Direct-mapped, one-word-per-line instruction cache. Hits answer in one cycle;
// misses refill the line with four sequential byte reads on the 8-bit memory port.
module inst_fetch_cache #(
  parameter int INDEX_W = 6,
  parameter int ADDR_W  = 18
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rdy_i,
  input  logic        req_i,
  input  logic [31:0] pc_i,
  input  logic        flush_i,
  output logic [31:0] inst_o,
  output logic        inst_valid_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_grant_i,
  input  logic [7:0]  mem_data_i
);
  localparam int LINES = 1 << INDEX_W;
  localparam int TAG_W = ADDR_W - INDEX_W - 2;

  // Memory handshake: a byte read transfers in any cycle where mem_req_o and
  // mem_grant_i are both high; its data is on mem_data_i the following cycle.
  typedef enum logic [1:0] {IDLE, FILL, RESP} state_t;
  state_t state, state_next;

  logic [31:0]      data_mem [LINES];
  logic [TAG_W-1:0] tag_mem  [LINES];
  logic [LINES-1:0] valid_q;

  logic [INDEX_W-1:0] fill_idx;
  logic [TAG_W-1:0]   fill_tag;
  logic [31:0]        fill_word;
  logic [31:0]        mem_addr_q;
  logic [31:0]        hit_data_q;
  logic [2:0]         issue_cnt;
  logic [2:0]         recv_cnt;
  logic               granted_d;
  logic               cancel_q;
  logic               hit_valid_q;

  logic [INDEX_W-1:0] lookup_idx;
  logic [TAG_W-1:0]   lookup_tag;
  logic               lookup;
  logic               hit;
  logic               miss;
  logic               issue_fire;
  logic               last_byte;

  assign lookup_idx = pc_i[INDEX_W+1:2];
  assign lookup_tag = pc_i[ADDR_W-1:INDEX_W+2];
  assign lookup     = (state == IDLE) && req_i && !flush_i;
  assign hit        = lookup && valid_q[lookup_idx] && (tag_mem[lookup_idx] == lookup_tag);
  assign miss       = lookup && !hit;

  assign mem_req_o  = (state == FILL) && (issue_cnt < 3'd4);
  assign issue_fire = mem_req_o && mem_grant_i;
  assign last_byte  = (state == FILL) && granted_d && (recv_cnt == 3'd3);
  assign mem_addr_o = mem_addr_q;

  // The fill response is combinational in RESP so a flush arriving in that very
  // cycle can still suppress it.
  assign inst_valid_o = hit_valid_q || ((state == RESP) && !cancel_q && !(rdy_i && flush_i));
  assign inst_o       = (state == RESP) ? fill_word : hit_data_q;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (miss) state_next = FILL;
      FILL:    if (last_byte) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      valid_q     <= '0;
      hit_valid_q <= 1'b0;
      hit_data_q  <= '0;
      mem_addr_q  <= '0;
      fill_idx    <= '0;
      fill_tag    <= '0;
      fill_word   <= '0;
      issue_cnt   <= '0;
      recv_cnt    <= '0;
      granted_d   <= 1'b0;
      cancel_q    <= 1'b0;
    end else if (rdy_i) begin
      state       <= state_next;
      hit_valid_q <= hit;
      if (hit) hit_data_q <= data_mem[lookup_idx];
      case (state)
        IDLE: begin
          if (miss) begin
            fill_idx   <= lookup_idx;
            fill_tag   <= lookup_tag;
            mem_addr_q <= pc_i & 32'hFFFF_FFFC;
            issue_cnt  <= '0;
            recv_cnt   <= '0;
            granted_d  <= 1'b0;
            cancel_q   <= 1'b0;
          end
        end
        FILL: begin
          granted_d <= issue_fire;
          if (issue_fire) begin
            issue_cnt <= issue_cnt + 3'd1;
            // Hold the last byte address once all four reads are out.
            if (issue_cnt < 3'd3) mem_addr_q <= mem_addr_q + 32'd1;
          end
          if (granted_d) begin
            fill_word[{recv_cnt[1:0], 3'b000} +: 8] <= mem_data_i;
            recv_cnt <= recv_cnt + 3'd1;
          end
          if (flush_i) cancel_q <= 1'b1;
          if (last_byte) valid_q[fill_idx] <= 1'b1;
        end
        RESP:    cancel_q <= 1'b0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && rdy_i && last_byte) begin
      data_mem[fill_idx] <= {mem_data_i, fill_word[23:0]};
      tag_mem[fill_idx]  <= fill_tag;
    end
  end
endmodule

// File: tb/tb_inst_fetch_cache.sv
// Self-checking bench for inst_fetch_cache: byte-memory responder, line-table
// reference model and per-scenario test tasks.
module tb_inst_fetch_cache;
  localparam int INDEX_W = 6;
  localparam int ADDR_W  = 18;
  localparam int LINES   = 1 << INDEX_W;
  localparam logic [63:0] ALL = '1;

  logic        clk = 1'b0;
  logic        rst_n, rdy_i, req_i, flush_i, mem_grant_i;
  logic [31:0] pc_i;
  logic [7:0]  mem_data_i;
  logic [31:0] inst_o, mem_addr_o;
  logic        inst_valid_o, mem_req_o;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [7:0]  mem_img [bit [31:0]];
  logic [31:0] issue_log[$];
  logic [31:0] addr_trace[$];
  logic [31:0] exp_q[$];

  bit          model_valid [LINES];
  int          model_tag   [LINES];
  logic [31:0] model_data  [LINES];

  inst_fetch_cache #(.INDEX_W(INDEX_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .rdy_i(rdy_i), .req_i(req_i), .pc_i(pc_i),
    .flush_i(flush_i), .inst_o(inst_o), .inst_valid_o(inst_valid_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
    .mem_grant_i(mem_grant_i), .mem_data_i(mem_data_i)
  );

  always #5 clk = ~clk;

  // ---------------- memory image and reference model ----------------
  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    logic [31:0] h;
    if (mem_img.exists(a)) return mem_img[a];
    h = a * 32'h9E37_79B1;
    return h[23:16];
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] pc);
    logic [31:0] base;
    logic [31:0] w;
    base = pc - (pc % 4);
    w = 0;
    for (int k = 0; k < 4; k++) w = w + (32'(mem_byte(base + k)) << (8 * k));
    return w;
  endfunction

  function automatic void set_word(input logic [31:0] a, input logic [31:0] w);
    for (int k = 0; k < 4; k++) mem_img[a + k] = 8'(w >> (8 * k));
  endfunction

  function automatic int line_of(input logic [31:0] pc);
    return int'((pc / 4) % LINES);
  endfunction

  function automatic int tag_of(input logic [31:0] pc);
    return int'((pc % (32'd1 << ADDR_W)) / (4 * LINES));
  endfunction

  function automatic bit model_hit(input logic [31:0] pc);
    return model_valid[line_of(pc)] && model_tag[line_of(pc)] == tag_of(pc);
  endfunction

  function automatic void model_fill(input logic [31:0] pc);
    model_valid[line_of(pc)] = 1'b1;
    model_tag[line_of(pc)]   = tag_of(pc);
    model_data[line_of(pc)]  = mem_word(pc);
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < LINES; i++) model_valid[i] = 1'b0;
  endfunction

  // Miss latency: four effective grants (grant in a ready cycle), then the last
  // byte lands in the next ready cycle and the response follows one cycle later.
  function automatic int exp_latency(input logic [63:0] gnt, input logic [63:0] rdy);
    int grants = 0;
    int k = 1;
    while (grants < 4 && k < 60) begin
      if (gnt[k] && rdy[k]) grants++;
      k++;
    end
    while (!rdy[k] && k < 60) k++;
    return k + 1;
  endfunction

  // ---------------- memory manager responder ----------------
  initial begin
    logic        fire, rdy_s;
    logic [31:0] a;
    forever begin
      @(negedge clk);
      fire  = rst_n && rdy_i && mem_req_o && mem_grant_i;
      rdy_s = rdy_i;
      a     = mem_addr_o;
      if (fire) issue_log.push_back(a);
      @(posedge clk);
      #1;
      if (rdy_s) mem_data_i = fire ? mem_byte(a) : 8'($urandom);
    end
  end

  // ---------------- driver ----------------
  // Pattern bit k applies to cycle t+k, where t is the lookup cycle.
  task automatic run_fetch(input logic [31:0] pc, input logic [63:0] gnt, input logic [63:0] rdy,
                           input logic [63:0] flush, input logic [63:0] rst, input int ncyc,
                           output int lat, output logic [31:0] data, output int n_valid, output int n_req);
    lat = -1; data = '0; n_valid = 0; n_req = 0;
    for (int k = 0; k < ncyc; k++) begin
      @(posedge clk);
      #1;
      if (k == 0) begin issue_log.delete(); addr_trace.delete(); end
      req_i = (k == 0); pc_i = pc; mem_grant_i = gnt[k]; rdy_i = rdy[k];
      flush_i = flush[k]; rst_n = ~rst[k];
      @(negedge clk);
      addr_trace.push_back(mem_addr_o);
      if (mem_req_o) n_req++;
      if (k > 0 && inst_valid_o) begin
        n_valid++;
        if (lat < 0) begin lat = k; data = inst_o; end
      end
    end
    @(posedge clk);
    #1;
    req_i = 1'b0; mem_grant_i = 1'b0; rdy_i = 1'b1; flush_i = 1'b0; rst_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests_run++; if (inst_valid_o !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b expected 0", inst_valid_o); end
    tests_run++; if (inst_o !== 32'h0) begin tests_failed++; $display("FAIL reset_inst: got %h expected 0", inst_o); end
    tests_run++; if (mem_req_o !== 1'b0) begin tests_failed++; $display("FAIL reset_mem_req: got %b expected 0", mem_req_o); end
    tests_run++; if (mem_addr_o !== 32'h0) begin tests_failed++; $display("FAIL reset_mem_addr: got %h expected 0", mem_addr_o); end
    @(posedge clk); #1; rst_n = 1'b1;
    model_clear();
  endtask

  task automatic test_first_fill();
    int lat, nv, nr;
    logic [31:0] d;
    set_word(32'h0, 32'h0000_0013);
    run_fetch(32'h0, ALL, ALL, '0, '0, 9, lat, d, nv, nr);
    model_fill(32'h0);
    exp_q.delete();
    for (int k = 0; k < 4; k++) exp_q.push_back(32'(k));
    tests_run++; if (issue_log.size() != 4) begin tests_failed++; $display("FAIL fill0_issue_count: got %0d expected 4", issue_log.size()); end
    for (int i = 0; i < 4; i++) begin
      tests_run++; if (issue_log[i] !== exp_q[i]) begin tests_failed++; $display("FAIL fill0_addr%0d: got %h expected %h", i, issue_log[i], exp_q[i]); end
    end
    tests_run++; if (lat != 6) begin tests_failed++; $display("FAIL fill0_latency: got %0d expected 6", lat); end
    tests_run++; if (d !== 32'h0000_0013) begin tests_failed++; $display("FAIL fill0_data: got %h expected 00000013", d); end
    tests_run++; if (nv != 1) begin tests_failed++; $display("FAIL fill0_pulses: got %0d expected 1", nv); end
    run_fetch(32'h0, ALL, ALL, '0, '0, 3, lat, d, nv, nr);
    tests_run++; if (lat != 1) begin tests_failed++; $display("FAIL hit0_latency: got %0d expected 1", lat); end
    tests_run++; if (nr != 0) begin tests_failed++; $display("FAIL hit0_mem_req: got %0d cycles expected 0", nr); end
    tests_run++; if (d !== 32'h0000_0013) begin tests_failed++; $display("FAIL hit0_data: got %h expected 00000013", d); end
  endtask

  task automatic test_grant_gaps();
    int lat, nv, nr;
    logic [31:0] d;
    set_word(32'h100, $urandom);
    run_fetch(32'h100, ALL & ~64'hC, ALL, '0, '0, 11, lat, d, nv, nr);
    model_fill(32'h100);
    tests_run++; if (addr_trace[2] !== 32'h101 || addr_trace[3] !== 32'h101) begin tests_failed++; $display("FAIL gap_addr_hold: got %h %h expected 00000101", addr_trace[2], addr_trace[3]); end
    tests_run++; if (addr_trace[5] !== 32'h102) begin tests_failed++; $display("FAIL gap_addr_resume: got %h expected 00000102", addr_trace[5]); end
    tests_run++; if (lat != 8) begin tests_failed++; $display("FAIL gap_latency: got %0d expected 8", lat); end
    tests_run++; if (d !== mem_word(32'h100)) begin tests_failed++; $display("FAIL gap_data: got %h expected %h", d, mem_word(32'h100)); end
  endtask

  task automatic test_conflict();
    int lat, nv, nr;
    logic [31:0] d;
    logic [31:0] pcs[3];
    logic [31:0] words[3];
    set_word(32'h004, 32'hAABB_CCDD);
    set_word(32'h104, 32'h1122_3344);
    pcs   = '{32'h004, 32'h104, 32'h004};
    words = '{32'hAABB_CCDD, 32'h1122_3344, 32'hAABB_CCDD};
    for (int i = 0; i < 3; i++) begin
      run_fetch(pcs[i], ALL, ALL, '0, '0, 9, lat, d, nv, nr);
      model_fill(pcs[i]);
      tests_run++; if (lat != 6) begin tests_failed++; $display("FAIL conflict%0d_latency: got %0d expected 6", i, lat); end
      tests_run++; if (d !== words[i]) begin tests_failed++; $display("FAIL conflict%0d_data: got %h expected %h", i, d, words[i]); end
    end
  endtask

  task automatic test_flush_fill();
    int lat, nv, nr;
    logic [31:0] d;
    run_fetch(32'h008, ALL, ALL, 64'h8, '0, 9, lat, d, nv, nr);
    model_fill(32'h008);
    tests_run++; if (nv != 0) begin tests_failed++; $display("FAIL flush_fill_pulses: got %0d expected 0", nv); end
    run_fetch(32'h008, ALL, ALL, '0, '0, 3, lat, d, nv, nr);
    tests_run++; if (lat != 1) begin tests_failed++; $display("FAIL flush_refetch_latency: got %0d expected 1", lat); end
    tests_run++; if (d !== mem_word(32'h008)) begin tests_failed++; $display("FAIL flush_refetch_data: got %h expected %h", d, mem_word(32'h008)); end
  endtask

  task automatic test_flush_idle_hit();
    int lat, nv, nr;
    logic [31:0] d;
    run_fetch(32'h008, ALL, ALL, 64'h1, '0, 3, lat, d, nv, nr);
    tests_run++; if (nv != 0) begin tests_failed++; $display("FAIL flush_idle_pulses: got %0d expected 0", nv); end
    tests_run++; if (nr != 0) begin tests_failed++; $display("FAIL flush_idle_mem_req: got %0d expected 0", nr); end
  endtask

  task automatic test_back_to_back();
    int lat, nv, nr;
    logic [31:0] d;
    logic [31:0] exp_w;
    for (int i = 0; i < 4; i++) begin
      if (!model_hit(32'(4 * i))) begin
        run_fetch(32'(4 * i), ALL, ALL, '0, '0, 9, lat, d, nv, nr);
        model_fill(32'(4 * i));
      end
    end
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      req_i = (k < 4); pc_i = 32'(4 * k);
      @(negedge clk);
      if (k >= 1 && k <= 4) begin
        exp_w = model_data[line_of(32'(4 * (k - 1)))];
        tests_run++; if (inst_valid_o !== 1'b1) begin tests_failed++; $display("FAIL b2b%0d_valid: got %b expected 1", k, inst_valid_o); end
        tests_run++; if (inst_o !== exp_w) begin tests_failed++; $display("FAIL b2b%0d_data: got %h expected %h", k, inst_o, exp_w); end
      end else if (k == 5) begin
        tests_run++; if (inst_valid_o !== 1'b0) begin tests_failed++; $display("FAIL b2b_tail_valid: got %b expected 0", inst_valid_o); end
      end
    end
    @(posedge clk); #1; req_i = 1'b0;
  endtask

  task automatic test_alias();
    int lat, nv, nr;
    logic [31:0] d;
    run_fetch(32'h0004_0000, ALL, ALL, '0, '0, 3, lat, d, nv, nr);
    tests_run++; if (lat != 1 || nr != 0) begin tests_failed++; $display("FAIL alias_hit: got latency %0d req %0d expected 1 and 0", lat, nr); end
    tests_run++; if (d !== model_data[0]) begin tests_failed++; $display("FAIL alias_data: got %h expected %h", d, model_data[0]); end
  endtask

  task automatic test_rdy_pause();
    int lat, nv, nr;
    logic [31:0] d;
    run_fetch(32'h200, ALL, ALL & ~64'h1C, '0, '0, 12, lat, d, nv, nr);
    model_fill(32'h200);
    tests_run++; if (lat != 9) begin tests_failed++; $display("FAIL pause_latency: got %0d expected 9", lat); end
    tests_run++; if (d !== mem_word(32'h200)) begin tests_failed++; $display("FAIL pause_data: got %h expected %h", d, mem_word(32'h200)); end
  endtask

  task automatic test_reset_midfill();
    int lat, nv, nr;
    logic [31:0] d;
    run_fetch(32'h300, ALL, ALL, '0, 64'h8, 10, lat, d, nv, nr);
    model_clear();
    tests_run++; if (nv != 0) begin tests_failed++; $display("FAIL rst_mid_pulses: got %0d expected 0", nv); end
    run_fetch(32'h0, ALL, ALL, '0, '0, 9, lat, d, nv, nr);
    model_fill(32'h0);
    tests_run++; if (lat != 6 || nr != 4) begin tests_failed++; $display("FAIL rst_refill: got latency %0d req %0d expected 6 and 4", lat, nr); end
    tests_run++; if (d !== 32'h0000_0013) begin tests_failed++; $display("FAIL rst_refill_data: got %h expected 00000013", d); end
  endtask

  task automatic test_random();
    int lat, nv, nr, elat;
    logic [31:0] d, pc, exp_w;
    logic [63:0] gnt, rdy;
    bit h;
    for (int i = 0; i < 40; i++) begin
      pc = (32'($urandom_range(0, 3)) << 18) | (32'($urandom_range(0, 3)) << 8) |
           (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
      h     = model_hit(pc);
      exp_w = h ? model_data[line_of(pc)] : mem_word(pc);
      gnt   = {32'hFFFF_FFFF, $urandom | 32'hFFFF_0000};
      rdy   = h ? ALL : ~(64'($urandom) & 64'h3E);
      elat  = h ? 1 : exp_latency(gnt, rdy);
      run_fetch(pc, gnt, rdy, '0, '0, elat + 2, lat, d, nv, nr);
      if (!h) model_fill(pc);
      tests_run++; if (lat != elat) begin tests_failed++; $display("FAIL rand%0d_latency: pc %h got %0d expected %0d", i, pc, lat, elat); end
      tests_run++; if (d !== exp_w) begin tests_failed++; $display("FAIL rand%0d_data: pc %h got %h expected %h", i, pc, d, exp_w); end
      tests_run++; if (nv != 1 || (h && nr != 0)) begin tests_failed++; $display("FAIL rand%0d_pulse: pc %h got pulses %0d req %0d expected 1 and %0d", i, pc, nv, nr, h ? 0 : nr); end
    end
  endtask

  initial begin
    rst_n = 1'b0; rdy_i = 1'b1; req_i = 1'b0; pc_i = '0; flush_i = 1'b0;
    mem_grant_i = 1'b0; mem_data_i = '0;
    test_reset();
    test_first_fill();
    test_grant_gaps();
    test_conflict();
    test_flush_fill();
    test_flush_idle_hit();
    test_back_to_back();
    test_alias();
    test_rdy_pause();
    test_reset_midfill();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/inst_fetch_cache.md
# inst_fetch_cache

Direct-mapped instruction cache between the core's IF stage and the byte-wide memory manager. Turns 32-bit instruction fetch requests into single-cycle hits, or into a 4-byte sequential fill on the 8-bit memory bus on a miss. Holds 1 instruction word per line. Frees the shared memory port for MEM-stage traffic whenever fetches hit.

## Interface
Parameters:
- INDEX_W, 6: index bits; LINES = 2^INDEX_W lines of 32 bits.
- ADDR_W, 18: significant address bits. Tag = pc_i[ADDR_W-1 : INDEX_W+2].

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- rdy_i  in  1  global ready; when low, all state, outputs and valid bits are frozen.
- req_i  in  1  core fetch request; core holds pc_i stable while req_i is high.
- pc_i  in  32  fetch address; bits [1:0] are ignored (always word fetch).
- flush_i  in  1  branch/jump redirect; cancels delivery of the current request.
- inst_o  out  32  fetched instruction, little-endian assembled.
- inst_valid_o  out  1  one-cycle pulse; inst_o is valid for the accepted pc.
- mem_req_o  out  1  byte read request to the memory manager.
- mem_addr_o  out  32  byte address of the request.
- mem_grant_i  in  1  manager accepted the request this cycle (low while MEM stage owns the port).
- mem_data_i  in  8  read data; valid the cycle after a granted request.

## Operation
- Storage: data[LINES] 32b, tag[LINES], valid[LINES]. Only valid bits are reset.
- IDLE: when req_i=1 and flush_i=0, look up index pc_i[INDEX_W+1:2].
  - Hit: next cycle inst_o = data[idx] and inst_valid_o = 1; the FSM stays in IDLE.
  - Miss: latch pc[31:2] into fill_pc, clear byte counters, go to FILL.
- FILL: issue byte addresses {fill_pc,2'b00}+k for k=0..3 in order.
  - mem_req_o = 1 while issue count < 4.
  - The issue counter advances only in cycles with mem_grant_i = 1.
  - A 1-bit granted_d flag records a grant. When it is set, the next cycle captures mem_data_i into byte lane recv_cnt and advances recv_cnt.
  - Byte k goes to bits [8k+7:8k].
  - When recv_cnt reaches 4: write data/tag and set valid for the fill index, then go to RESP.
- RESP: drive inst_o = assembled word and inst_valid_o = 1 for one cycle, unless the fill was cancelled. Then return to IDLE. Requests are not accepted in RESP.
- flush_i:
  - In IDLE: the lookup is suppressed, with no response.
  - In FILL or RESP: sets a cancel flag. The fill still completes and the line is written, but inst_valid_o stays 0 in RESP.
  - The cancel flag clears on return to IDLE.
- No grant is ever abandoned mid-fill, so the memory manager never sees a partial transaction dropped.
- Reset values: state = IDLE, all valid = 0, inst_valid_o = 0, inst_o = 0, mem_req_o = 0, mem_addr_o = 0, counters = 0, cancel = 0.

## Timing
- Hit latency: request in cycle t, inst_valid_o in t+1. Back-to-back hits sustain 1 per cycle.
- Miss latency with continuous grant:
  - lookup at t;
  - issues at t+1..t+4;
  - bytes captured at t+2..t+5;
  - line written at the end of t+5;
  - RESP at t+6.
  - Each cycle without a grant adds 1 cycle.
- mem_addr_o is registered and changes only after a granted cycle. It holds its value while grant is low.
- rst_n low mid-fill: immediate return to IDLE with all lines invalid. Any in-flight memory byte is ignored.
- rdy_i low: the cycle is a complete no-op, including mem_data_i capture. The manager is paused identically.
- Simultaneous flush_i and a hit in IDLE: no inst_valid_o next cycle.
- A fill targeting an index that holds a different valid tag overwrites it (no victim).
- pc_i aliasing: the address is masked to ADDR_W bits, so pc values differing only above ADDR_W share a line.

## Test plan
- Reset, then fetch pc=0x0000 with memory bytes 13 00 00 00 and constant grant:
  - mem_addr_o sequence 0x0,0x1,0x2,0x3;
  - inst_valid_o at cycle t+6 with inst_o=0x00000013;
  - refetch pc=0x0000 gives inst_valid_o at t+1 with no mem_req_o.
- Miss at pc=0x0100 with mem_grant_i low for the 2nd and 3rd cycles of FILL:
  - byte addresses hold during the low cycles;
  - word assembles correctly;
  - response at t+8.
- Conflict: fill 0x0004 (=0xAABBCCDD), then 0x0104 (=0x11223344), then fetch 0x0004:
  - the third fetch misses and refills, returning 0xAABBCCDD.
- flush_i pulsed in the 3rd cycle of a fill of 0x0008:
  - no inst_valid_o;
  - the next fetch of 0x0008 hits in 1 cycle.
- Stream of 4 hits at 0x0,0x4,0x8,0xC: inst_valid_o high 4 consecutive cycles with the correct words.
- rdy_i low for 3 cycles mid-fill and rst_n low mid-fill:
  - the rdy_i pause extends latency by exactly 3;
  - after reset, a previously cached pc misses again.
